// File: rtl/hand_bbox_extractor_pkg.sv
// Shared types and constants for the hand bounding-box extractor.
// Holds the FSM state type, the default active-area size and the
// coordinate/count types used by the top and the accumulator.
package hand_bbox_extractor_pkg;

  localparam int DEFAULT_H_ACTIVE = 640;
  localparam int DEFAULT_V_ACTIVE = 480;

  localparam int COORD_W = 11;
  localparam int COUNT_W = 19;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COUNT_W-1:0] pix_count_t;

  // Min trackers start at the largest coordinate so the first hand pixel always wins.
  localparam coord_t COORD_MIN_INIT = 11'h7FF;
  localparam coord_t COORD_MAX_INIT = 11'h000;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACCUM    = 2'd1,
    FLUSH    = 2'd2,
    PUBLISH  = 2'd3
  } bbox_state_t;

endpackage

// File: rtl/hand_bbox_extractor_bbox_minmax_acc.sv
// Min/max/count accumulator for hand pixel coordinates.
// clear returns the trackers to their initial values; clear together with
// enable restarts the frame with the presented pixel as its only member.
module bbox_minmax_acc
  import hand_bbox_extractor_pkg::*;
(
  input  logic       VGA_CLK,
  input  logic       RST,
  input  logic       clear,
  input  logic       enable,
  input  coord_t     x,
  input  coord_t     y,
  output coord_t     min_x,
  output coord_t     max_x,
  output coord_t     min_y,
  output coord_t     max_y,
  output pix_count_t count
);

  localparam pix_count_t COUNT_MAX = '1;

  // Track the extreme coordinates and a saturating count of hand pixels.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      min_x <= COORD_MIN_INIT;
      max_x <= COORD_MAX_INIT;
      min_y <= COORD_MIN_INIT;
      max_y <= COORD_MAX_INIT;
      count <= '0;
    end else if (clear) begin
      if (enable) begin
        min_x <= x;
        max_x <= x;
        min_y <= y;
        max_y <= y;
        count <= pix_count_t'(1);
      end else begin
        min_x <= COORD_MIN_INIT;
        max_x <= COORD_MAX_INIT;
        min_y <= COORD_MIN_INIT;
        max_y <= COORD_MAX_INIT;
        count <= '0;
      end
    end else if (enable) begin
      if (x < min_x) min_x <= x;
      if (x > max_x) max_x <= x;
      if (y < min_y) min_y <= y;
      if (y > max_y) max_y <= y;
      if (count != COUNT_MAX) count <= count + pix_count_t'(1);
    end
  end

endmodule

// File: rtl/hand_bbox_extractor.sv
// Per-frame hand bounding-box extractor.
// Stage 1 registers the pixel and its position and classifies it as hand or
// not; stage 2 folds hand pixels into the accumulator. The FSM frames the
// accumulation between start-of-frame and the first blanking line, waits for
// the pipeline to drain, then publishes the box with a one-cycle strobe.
module hand_bbox_extractor #(
  parameter int H_ACTIVE   = hand_bbox_extractor_pkg::DEFAULT_H_ACTIVE,
  parameter int V_ACTIVE   = hand_bbox_extractor_pkg::DEFAULT_V_ACTIVE,
  parameter int THRESHOLD  = 128,
  parameter int MIN_PIXELS = 64
) (
  input  logic        VGA_CLK,
  input  logic        RST,
  input  logic [7:0]  pixel_in,
  input  logic [12:0] VGA_H_CNT,
  input  logic [12:0] VGA_V_CNT,
  output logic [10:0] hand_x,
  output logic [10:0] hand_y,
  output logic [10:0] hand_width,
  output logic [10:0] hand_height,
  output logic        hand_detected,
  output logic        bbox_valid
);

  import hand_bbox_extractor_pkg::*;

  logic        s1_hand;
  coord_t      s1_x;
  coord_t      s1_y;
  logic        s1_sof;
  logic        s1_eof;

  bbox_state_t state;
  bbox_state_t next_state;
  logic        flush_cnt;

  logic        acc_clear;
  logic        acc_enable;
  logic        load_outputs;

  coord_t      acc_min_x;
  coord_t      acc_max_x;
  coord_t      acc_min_y;
  coord_t      acc_max_y;
  pix_count_t  acc_count;

  // Stage 1: capture the position and decide whether the pixel belongs to the hand.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      s1_hand <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_sof  <= 1'b0;
      s1_eof  <= 1'b0;
    end else begin
      s1_hand <= (pixel_in >= 8'(THRESHOLD)) &&
                 (VGA_H_CNT < 13'(H_ACTIVE)) &&
                 (VGA_V_CNT < 13'(V_ACTIVE));
      s1_x    <= VGA_H_CNT[10:0];
      s1_y    <= VGA_V_CNT[10:0];
      s1_sof  <= (VGA_H_CNT == 13'd0) && (VGA_V_CNT == 13'd0);
      s1_eof  <= (VGA_H_CNT == 13'd0) && (VGA_V_CNT == 13'(V_ACTIVE));
    end
  end

  // FSM state register.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) state <= WAIT_SOF;
    else     state <= next_state;
  end

  // Counts the drain cycles spent in FLUSH.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST)                flush_cnt <= 1'b0;
    else if (state == FLUSH) flush_cnt <= ~flush_cnt;
    else                    flush_cnt <= 1'b0;
  end

  // Next-state logic: only start-of-frame opens a frame and only the first blanking line closes it.
  always_comb begin
    next_state = state;
    unique case (state)
      WAIT_SOF: if (s1_sof) next_state = ACCUM;
      ACCUM:    if (s1_eof) next_state = FLUSH;
      FLUSH:    if (flush_cnt) next_state = PUBLISH;
      PUBLISH:  next_state = WAIT_SOF;
      default:  next_state = WAIT_SOF;
    endcase
  end

  // Output decode: accumulator control, publish load and the valid strobe.
  always_comb begin
    acc_clear    = 1'b0;
    acc_enable   = 1'b0;
    load_outputs = 1'b0;
    bbox_valid   = 1'b0;
    unique case (state)
      WAIT_SOF: begin
        acc_clear  = 1'b1;
        acc_enable = s1_sof && s1_hand;
      end
      ACCUM: begin
        acc_enable = s1_hand;
      end
      FLUSH: begin
        load_outputs = flush_cnt;
      end
      PUBLISH: begin
        bbox_valid = 1'b1;
      end
      default: begin
        acc_clear = 1'b1;
      end
    endcase
  end

  bbox_minmax_acc u_acc (
    .VGA_CLK (VGA_CLK),
    .RST     (RST),
    .clear   (acc_clear),
    .enable  (acc_enable),
    .x       (s1_x),
    .y       (s1_y),
    .min_x   (acc_min_x),
    .max_x   (acc_max_x),
    .min_y   (acc_min_y),
    .max_y   (acc_max_y),
    .count   (acc_count)
  );

  // Result registers: loaded on entry to PUBLISH so they are valid alongside the strobe, held otherwise.
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      hand_x        <= '0;
      hand_y        <= '0;
      hand_width    <= '0;
      hand_height   <= '0;
      hand_detected <= 1'b0;
    end else if (load_outputs) begin
      if (acc_count >= pix_count_t'(MIN_PIXELS)) begin
        hand_x        <= acc_min_x;
        hand_y        <= acc_min_y;
        hand_width    <= acc_max_x - acc_min_x + 11'd1;
        hand_height   <= acc_max_y - acc_min_y + 11'd1;
        hand_detected <= 1'b1;
      end else begin
        hand_x        <= '0;
        hand_y        <= '0;
        hand_width    <= '0;
        hand_height   <= '0;
        hand_detected <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hand_bbox_extractor.sv
// Self-checking bench for hand_bbox_extractor on a reduced frame size.
// Stimulus scans whole frames from an image array; a frame-level model
// pushes the expected box when the frame closes and a monitor compares it
// against each bbox_valid strobe and checks that outputs hold in between.
module tb_hand_bbox_extractor;

  localparam int H_ACT = 32;
  localparam int V_ACT = 24;
  localparam int H_TOT = 40;
  localparam int V_TOT = 28;
  localparam int TH    = 128;
  localparam int MINP  = 12;

  logic        VGA_CLK = 1'b0;
  logic        RST;
  logic [7:0]  pixel_in;
  logic [12:0] VGA_H_CNT;
  logic [12:0] VGA_V_CNT;
  logic [10:0] hand_x;
  logic [10:0] hand_y;
  logic [10:0] hand_width;
  logic [10:0] hand_height;
  logic        hand_detected;
  logic        bbox_valid;

  always #5 VGA_CLK = ~VGA_CLK;

  hand_bbox_extractor #(
    .H_ACTIVE   (H_ACT),
    .V_ACTIVE   (V_ACT),
    .THRESHOLD  (TH),
    .MIN_PIXELS (MINP)
  ) dut (
    .VGA_CLK       (VGA_CLK),
    .RST           (RST),
    .pixel_in      (pixel_in),
    .VGA_H_CNT     (VGA_H_CNT),
    .VGA_V_CNT     (VGA_V_CNT),
    .hand_x        (hand_x),
    .hand_y        (hand_y),
    .hand_width    (hand_width),
    .hand_height   (hand_height),
    .hand_detected (hand_detected),
    .bbox_valid    (bbox_valid)
  );

  typedef struct {
    int x;
    int y;
    int w;
    int h;
    int det;
  } box_t;

  box_t exp_q[$];
  box_t held;

  int tests = 0;
  int fails = 0;

  logic [7:0] img [V_TOT][H_TOT];

  bit in_frame = 1'b0;
  int m_minx, m_maxx, m_miny, m_maxy, m_cnt;

  task automatic checkOutput(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Drives one pixel for one clock and feeds the frame-level model.
  task automatic applyStimulus(input logic [7:0] p, input int h, input int v);
    box_t b;
    pixel_in  = p;
    VGA_H_CNT = 13'(h);
    VGA_V_CNT = 13'(v);
    if (!in_frame && h == 0 && v == 0) begin
      in_frame = 1'b1;
      m_minx = 1 << 30;
      m_miny = 1 << 30;
      m_maxx = -1;
      m_maxy = -1;
      m_cnt  = 0;
    end
    if (in_frame) begin
      if (v == V_ACT && h == 0) begin
        if (m_cnt >= MINP) begin
          b.x = m_minx;
          b.y = m_miny;
          b.w = m_maxx - m_minx + 1;
          b.h = m_maxy - m_miny + 1;
          b.det = 1;
        end else begin
          b.x = 0; b.y = 0; b.w = 0; b.h = 0; b.det = 0;
        end
        exp_q.push_back(b);
        in_frame = 1'b0;
      end else if (p >= TH && h < H_ACT && v < V_ACT) begin
        if (h < m_minx) m_minx = h;
        if (h > m_maxx) m_maxx = h;
        if (v < m_miny) m_miny = v;
        if (v > m_maxy) m_maxy = v;
        m_cnt++;
      end
    end
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_x"}, int'(hand_x), 0);
    checkOutput({tag, "_y"}, int'(hand_y), 0);
    checkOutput({tag, "_w"}, int'(hand_width), 0);
    checkOutput({tag, "_h"}, int'(hand_height), 0);
    checkOutput({tag, "_det"}, int'(hand_detected), 0);
    checkOutput({tag, "_valid"}, int'(bbox_valid), 0);
  endtask

  task automatic pulseReset();
    RST = 1'b1;
    in_frame = 1'b0;
    #2;
    checkZeroOutputs("midframe_reset");
    @(posedge VGA_CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic clearImg(input bit noisy);
    for (int v = 0; v < V_TOT; v++)
      for (int h = 0; h < H_TOT; h++)
        if (!noisy) img[v][h] = 8'd0;
        else if (h < H_ACT && v < V_ACT) img[v][h] = 8'($urandom_range(0, TH - 1));
        else img[v][h] = 8'($urandom_range(0, 255));
  endtask

  task automatic fillRect(input int x0, input int y0, input int x1, input int y1, input logic [7:0] val);
    for (int v = y0; v <= y1; v++)
      for (int h = x0; h <= x1; h++)
        img[v][h] = val;
  endtask

  // Scans one frame; optionally restarts the line counter after jump_line and resets at rst_line.
  task automatic sendFrame(input int rst_line, input int jump_line);
    if (jump_line >= 0)
      for (int v = 0; v <= jump_line; v++)
        for (int h = 0; h < H_TOT; h++)
          applyStimulus(img[v][h], h, v);
    for (int v = 0; v < V_TOT; v++)
      for (int h = 0; h < H_TOT; h++) begin
        if (v == rst_line && h == 0) pulseReset();
        applyStimulus(img[v][h], h, v);
      end
  endtask

  // Monitor: compare each strobe with the scoreboard and check outputs hold between strobes.
  always @(negedge VGA_CLK) begin
    box_t e;
    if (RST) begin
      held.x = 0; held.y = 0; held.w = 0; held.h = 0; held.det = 0;
    end else if (bbox_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_bbox_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pub_x", int'(hand_x), e.x);
        checkOutput("pub_y", int'(hand_y), e.y);
        checkOutput("pub_w", int'(hand_width), e.w);
        checkOutput("pub_h", int'(hand_height), e.h);
        checkOutput("pub_det", int'(hand_detected), e.det);
        held = e;
      end
    end else begin
      checkOutput("hold_x", int'(hand_x), held.x);
      checkOutput("hold_y", int'(hand_y), held.y);
      checkOutput("hold_w", int'(hand_width), held.w);
      checkOutput("hold_h", int'(hand_height), held.h);
      checkOutput("hold_det", int'(hand_detected), held.det);
    end
  end

  initial begin
    int x0, x1, y0, y1;
    RST       = 1'b1;
    pixel_in  = 8'd0;
    VGA_H_CNT = 13'(H_TOT - 1);
    VGA_V_CNT = 13'(V_TOT - 1);
    repeat (3) @(posedge VGA_CLK);
    #1;
    checkZeroOutputs("reset_state");
    RST = 1'b0;
    @(posedge VGA_CLK);
    #1;

    $display("[TB] solid block frame");
    clearImg(1'b0);
    fillRect(10, 5, 19, 14, 8'd255);
    sendFrame(-1, -1);

    $display("[TB] ten pixel frame below minimum");
    clearImg(1'b0);
    for (int i = 0; i < 10; i++) img[2 + i][3 + 2 * i] = 8'd255;
    sendFrame(-1, -1);

    $display("[TB] corner pixels frame");
    clearImg(1'b0);
    img[0][0] = 8'd255;
    img[V_ACT - 1][H_ACT - 1] = 8'd255;
    for (int i = 0; i < 10; i++) img[10][5 + i] = 8'd200;
    sendFrame(-1, -1);

    $display("[TB] blanking-only bright pixels frame");
    clearImg(1'b0);
    for (int v = 0; v < V_TOT; v++)
      for (int h = 0; h < H_TOT; h++)
        img[v][h] = (h < H_ACT && v < V_ACT) ? 8'd127 : 8'd255;
    sendFrame(-1, -1);

    $display("[TB] exact threshold and minimum count frame");
    clearImg(1'b0);
    for (int i = 0; i < MINP; i++) img[4 + (i % 3)][3 + i] = 8'(TH);
    sendFrame(-1, -1);

    $display("[TB] reset in the middle of a detecting frame");
    clearImg(1'b0);
    fillRect(2, 2, 25, 20, 8'd255);
    sendFrame(V_ACT / 2, -1);
    clearImg(1'b0);
    fillRect(6, 8, 12, 18, 8'd180);
    sendFrame(-1, -1);

    $display("[TB] line counter restart inside a frame");
    clearImg(1'b0);
    fillRect(4, 2, 9, 20, 8'd255);
    img[3][28] = 8'd255;
    sendFrame(-1, 6);

    $display("[TB] random frames");
    for (int f = 0; f < 8; f++) begin
      clearImg(1'b1);
      x0 = $urandom_range(0, H_ACT - 1);
      x1 = $urandom_range(x0, H_ACT - 1);
      y0 = $urandom_range(0, V_ACT - 1);
      y1 = $urandom_range(y0, V_ACT - 1);
      for (int v = y0; v <= y1; v++)
        for (int h = x0; h <= x1; h++)
          if ($urandom_range(0, 3) != 0) img[v][h] = 8'($urandom_range(TH, 255));
      sendFrame(-1, -1);
    end

    for (int i = 0; i < 20; i++) applyStimulus(8'd0, 5, V_TOT - 1);
    checkOutput("pending_publishes", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hand_bbox_extractor.md
HAND_BBOX_EXTRACTOR -- requirements
Module: hand_bbox_extractor

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter THRESHOLD, default 128, minimum pixel_in value counted as hand.
REQ-004 SHALL have parameter MIN_PIXELS, default 64, minimum hand-pixel count for a detection.
REQ-005 SHALL have port VGA_CLK, input, 1, pixel clock; all logic on its rising edge.
REQ-006 SHALL have port RST, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port pixel_in, input, 8, mask/luma pixel co-timed with the counters.
REQ-008 SHALL have port VGA_H_CNT, input, 13, horizontal position of pixel_in.
REQ-009 SHALL have port VGA_V_CNT, input, 13, vertical position of pixel_in.
REQ-010 SHALL have port hand_x, output, 11, left edge of the last frame's box.
REQ-011 SHALL have port hand_y, output, 11, top edge of the last frame's box.
REQ-012 SHALL have port hand_width, output, 11, box width in pixels.
REQ-013 SHALL have port hand_height, output, 11, box height in lines.
REQ-014 SHALL have port hand_detected, output, 1, last frame met MIN_PIXELS.
REQ-015 SHALL have port bbox_valid, output, 1, one-cycle pulse when the outputs update.

Function
REQ-016 SHALL treat a pixel as hand when pixel_in >= THRESHOLD, VGA_H_CNT < H_ACTIVE and VGA_V_CNT < V_ACTIVE.
REQ-017 SHALL register pixel_in and the counters in stage 1 (compare), then update the accumulators in stage 2; pipeline latency 2 cycles.
REQ-018 SHALL implement FSM states WAIT_SOF, ACCUM, FLUSH, PUBLISH.
REQ-019 WAIT_SOF: accumulators cleared; -> ACCUM on the input cycle with VGA_H_CNT==0 and VGA_V_CNT==0, and that pixel is accumulated.
REQ-020 ACCUM: per hand pixel, min_x/max_x/min_y/max_y updated, count incremented; -> FLUSH on the input cycle with VGA_V_CNT==V_ACTIVE and VGA_H_CNT==0.
REQ-021 FLUSH: held 2 cycles so in-flight pixels drain, then -> PUBLISH.
REQ-022 PUBLISH: outputs loaded, bbox_valid=1 for exactly this cycle, then -> WAIT_SOF.
REQ-023 Accumulator init: min_x=min_y=0x7FF, max_x=max_y=0, count=0.
REQ-024 count SHALL be 19 bits and saturate at all-ones, never wrap.
REQ-025 If count >= MIN_PIXELS: hand_x=min_x, hand_y=min_y, hand_width=max_x-min_x+1, hand_height=max_y-min_y+1 (11-bit unsigned), hand_detected=1.
REQ-026 If count < MIN_PIXELS: hand_x, hand_y, hand_width and hand_height SHALL be 0 and hand_detected=0.
REQ-027 A single hand pixel SHALL give width=1 and height=1 (when MIN_PIXELS<=1).
REQ-028 Outputs SHALL hold their values between PUBLISH cycles.
REQ-029 Counter jumps (e.g. V_CNT restarting mid-frame) in ACCUM SHALL NOT abort; only the REQ-020 condition ends a frame.
REQ-030 Pixels outside the active area SHALL never update the accumulators, including those with a high pixel_in during blanking.

Reset
REQ-031 On RST: FSM=WAIT_SOF, accumulators at init, all outputs 0, bbox_valid=0.
REQ-032 RST asserted mid-frame SHALL discard the partial frame; the first publish after reset follows the next full frame.

Structure
REQ-033 Shared package SHALL hold the FSM state enum, the default H_ACTIVE/V_ACTIVE constants and the 11-bit coordinate type.
REQ-034 One sub-module, bbox_minmax_acc (min/max/count accumulator with clear and enable), SHALL be instantiated; the FSM and output logic SHALL live in the top.

Verification
REQ-035 Frame with pixel_in=255 at x 100..149, y 200..239, else 0 -> bbox_valid pulse once; hand_x=100, hand_y=200, hand_width=50, hand_height=40, hand_detected=1.
REQ-036 Frame with 10 hand pixels and MIN_PIXELS=64 -> hand_detected=0 and all four box outputs 0.
REQ-037 pixel_in=255 only at x=639,y=479 and at x=0,y=0, MIN_PIXELS=1 -> hand_x=0, hand_y=0, hand_width=640, hand_height=480.
REQ-038 pixel_in=255 at H_CNT=700 (blanking) and pixel_in=127 in the active area, all other pixels 0 -> hand_detected=0.
REQ-039 RST pulsed at line 240 of a detecting frame -> outputs 0 and no bbox_valid until the end of the next full frame, which then reports that frame's box.
REQ-040 Two consecutive frames with different boxes -> exactly one bbox_valid per frame, and each frame's values are held until the next pulse.
